// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
//   Emulates a 4x4 active-low matrix keypad. A key code is accepted on a
//   valid/ready handshake. The key is then pressed for HOLD_CYCLES clocks and
//   released for RELEASE_CYCLES clocks. After that the block returns to idle
//   and pulses done. While the key is pressed, colread returns the key's
//   column whenever the scanner strobes the key's row on rowwrite.
//
//   Optional build macro: KEYPAD_BOUNCE_EN
//     When defined, the first BOUNCE_CYCLES clocks of PRESS and of RELEASE
//     toggle the contact every BOUNCE_PERIOD clocks. Each phase starts at its
//     nominal level and also ends at that level.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_code   in   [3:0] hex code of the key to press
//   key_valid  in   request strobe
//   key_ready  out  high in IDLE; accept = key_valid && key_ready at posedge
//   rowwrite   in   [3:0] active-low row strobe from the scanner
//   colread    out  [3:0] active-low column return (4'b1111 = no key)
//   busy       out  high in PRESS or RELEASE
//   done       out  one-cycle pulse when a sequence completes
// -----------------------------------------------------------------------------
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES    = 2000000,
  parameter int unsigned RELEASE_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned BOUNCE_CYCLES  = 262144,
  parameter int unsigned BOUNCE_PERIOD  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] rowwrite,
  output logic [3:0] colread,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LD  = CNT_W'(RELEASE_CYCLES - 1);

  // Configuration check at elaboration: every count must fit the counter.
  if (HOLD_CYCLES == 0 || RELEASE_CYCLES == 0 || BOUNCE_PERIOD == 0 ||
      64'(HOLD_CYCLES)    >= (64'd1 << CNT_W) ||
      64'(RELEASE_CYCLES) >= (64'd1 << CNT_W) ||
      64'(BOUNCE_CYCLES)  >= (64'd1 << CNT_W) ||
      64'(BOUNCE_PERIOD)  >= (64'd1 << CNT_W)) begin : g_cfg_err
    $error("keypad_emulator: cycle parameter is zero or exceeds CNT_W range");
  end

  // Returns {row, col} of a hex key in the keypad matrix.
  function automatic logic [3:0] decode(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hA: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hB: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hC: rc = {2'd2, 2'd3};
      4'hE: rc = {2'd3, 2'd0};
      4'h0: rc = {2'd3, 2'd1};
      4'hF: rc = {2'd3, 2'd2};
      default: rc = {2'd3, 2'd3};  // 4'hD
    endcase
    return rc;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       code_q;
  logic [3:0]       colread_q;
  logic             key_ready_q, busy_q, done_q;

  logic [3:0] rc;
  logic [3:0] row_pat, col_pat;
  logic       accept, cnt_zero, pressed;

  // NOTE: every signal assigned in always_comb gets a default first, so that
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    rc       = decode(code_q);
    row_pat  = ~(4'b0001 << rc[3:2]);
    col_pat  = ~(4'b0001 << rc[1:0]);
    accept   = (state_q == IDLE) && key_valid;
    cnt_zero = (cnt_q == '0);
  end

`ifdef KEYPAD_BOUNCE_EN
  if (BOUNCE_CYCLES >= HOLD_CYCLES || BOUNCE_CYCLES >= RELEASE_CYCLES) begin : g_bnc_err
    $error("keypad_emulator: BOUNCE_CYCLES must be shorter than both phases");
  end

  logic [CNT_W-1:0] bnc_win_q, bnc_per_q;
  logic             bnc_act_q, bnc_lvl_q;

  // The window counter limits how long bouncing lasts. The period counter
  // sets when the contact toggles. On each phase entry both counters reload
  // and the contact starts at the nominal level of that phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnc_win_q <= '0;
      bnc_per_q <= '0;
      bnc_act_q <= 1'b0;
      bnc_lvl_q <= 1'b0;
    end else if (accept || (state_q == PRESS && cnt_zero)) begin
      bnc_act_q <= (BOUNCE_CYCLES != 0);
      bnc_win_q <= CNT_W'(BOUNCE_CYCLES - 1);
      bnc_per_q <= CNT_W'(BOUNCE_PERIOD - 1);
      bnc_lvl_q <= accept;
    end else if (state_q == RELEASE && cnt_zero) begin
      bnc_act_q <= 1'b0;
    end else if (bnc_act_q) begin
      if (bnc_win_q == '0) bnc_act_q <= 1'b0;
      else                 bnc_win_q <= bnc_win_q - 1'b1;
      if (bnc_per_q == '0) begin
        bnc_per_q <= CNT_W'(BOUNCE_PERIOD - 1);
        bnc_lvl_q <= ~bnc_lvl_q;
      end else begin
        bnc_per_q <= bnc_per_q - 1'b1;
      end
    end
  end

  assign pressed = bnc_act_q ? bnc_lvl_q : (state_q == PRESS);
`else
  assign pressed = (state_q == PRESS);
`endif

  // NOTE: sequential state uses non-blocking assignments only. The reset is
  // in the sensitivity list, so colread returns to 4'b1111 as soon as rst_n
  // falls and does not wait for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= 4'h0;
      colread_q   <= 4'b1111;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // colread follows the current press level with one clock of latency.
      // A rowwrite value that is not exactly one-hot-low never matches.
      colread_q <= (pressed && rowwrite == row_pat) ? col_pat : 4'b1111;
      case (state_q)
        IDLE: if (accept) begin
          code_q      <= key_code;
          cnt_q       <= HOLD_LD;
          state_q     <= PRESS;
          key_ready_q <= 1'b0;
          busy_q      <= 1'b1;
        end
        PRESS: if (cnt_zero) begin
          cnt_q   <= REL_LD;
          state_q <= RELEASE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RELEASE: if (cnt_zero) begin
          state_q     <= IDLE;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign colread   = colread_q;
  assign key_ready = key_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
//   Directed and random stimulus for keypad_emulator with HOLD=8 and
//   RELEASE=4. The reference model keeps the edge number at which the last
//   request was accepted. Every expected output is derived from the distance
//   to that edge and from a keypad lookup table.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

  localparam int H = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] rowwrite;
  logic [3:0] colread;
  logic       busy;
  logic       done;

  keypad_emulator #(.HOLD_CYCLES(H), .RELEASE_CYCLES(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .rowwrite (rowwrite),
    .colread  (colread),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Physical keypad layout: kmap[row][col].
  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'hE, 4'h0, 4'hF, 4'hD}};

  // Model state.
  int         edge_n = 0;
  int         t0     = 0;
  bit         t0_v   = 0;
  logic [3:0] m_code = 4'h0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [3:0] row_pat_of(input logic [3:0] code);
    logic [3:0] p = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kmap[r][c] == code) p = ~(4'b0001 << r);
    return p;
  endfunction

  function automatic logic [3:0] col_pat_of(input logic [3:0] code);
    logic [3:0] p = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kmap[r][c] == code) p = ~(4'b0001 << c);
    return p;
  endfunction

  // Advance one clock, update the model, and compare all outputs at negedge.
  task automatic step();
    logic       kv, pressed_prev;
    logic [3:0] kc, rw, exp_col;
    int         d_old, d;
    kv = key_valid; kc = key_code; rw = rowwrite;
    @(posedge clk);
    edge_n++;
    d_old = edge_n - 1 - t0;
    if (kv && !(t0_v && d_old >= 0 && d_old <= H + R - 1)) begin
      t0 = edge_n; t0_v = 1; m_code = kc;
    end
    d = edge_n - t0;
    pressed_prev = t0_v && (d - 1 >= 0) && (d - 1 <= H - 1);
    exp_col = (pressed_prev && rw == row_pat_of(m_code)) ? col_pat_of(m_code) : 4'b1111;
    @(negedge clk);
    check("colread", colread, exp_col);
    check("busy",    {3'b0, busy},      {3'b0, t0_v && d >= 0 && d <= H + R - 1});
    check("ready",   {3'b0, key_ready}, {3'b0, !(t0_v && d >= 0 && d <= H + R - 1)});
    check("done",    {3'b0, done},      {3'b0, t0_v && d == H + R});
  endtask

  task automatic press(input logic [3:0] code, input logic [3:0] rw, input int idle_steps);
    key_code = code; key_valid = 1'b1; rowwrite = rw;
    step();
    key_valid = 1'b0;
    for (int i = 0; i < idle_steps; i++) step();
  endtask

  logic [3:0] rw_seq [14] = '{4'b1101, 4'b1101, 4'b1110, 4'b1100, 4'b1101, 4'b1111, 4'b0000,
                              4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
  logic [3:0] corner [4]  = '{4'h0, 4'hD, 4'hE, 4'hA};

  initial begin
    rst_n = 1'b0; key_code = 4'h0; key_valid = 1'b0; rowwrite = 4'b1111;
    #12;
    check("rst_colread", colread, 4'b1111);
    check("rst_ready",   {3'b0, key_ready}, 4'd1);
    check("rst_busy",    {3'b0, busy},      4'd0);
    check("rst_done",    {3'b0, done},      4'd0);
    @(negedge clk); rst_n = 1'b1;

    // Decode and timing for key 5, including rowwrite values that miss.
    key_code = 4'h5; key_valid = 1'b1; rowwrite = 4'b1101;
    step();
    key_valid = 1'b0; key_code = 4'h9;
    for (int i = 0; i < 14; i++) begin rowwrite = rw_seq[i]; step(); end

    // Handshake: a request for key 3 during key 7 is ignored. It stays valid
    // and is accepted after done.
    key_code = 4'h7; key_valid = 1'b1; rowwrite = 4'b1011;
    step();
    key_code = 4'h3;
    for (int i = 0; i < 4; i++) step();
    rowwrite = 4'b1110;
    for (int i = 0; i < 12; i++) step();
    key_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();

    // Corner codes, each strobed on its own row.
    for (int k = 0; k < 4; k++) press(corner[k], row_pat_of(corner[k]), 13);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 5);
      rowwrite  = (r < 4) ? ~(4'b0001 << r) : 4'($urandom_range(0, 15));
      step();
    end
    key_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();

    // Asynchronous reset in the middle of PRESS.
    press(4'h5, 4'b1101, 3);
    check("pre_rst_colread", colread, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    check("async_colread", colread, 4'b1111);
    check("async_ready",   {3'b0, key_ready}, 4'd1);
    check("async_busy",    {3'b0, busy},      4'd0);
    check("async_done",    {3'b0, done},      4'd0);
    t0_v = 0;
    @(negedge clk); rst_n = 1'b1;
    press(4'h1, 4'b1110, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Drives the colread lines of a 4x4 matrix keypad from the key-scanner's rowwrite strobes, acting as the keypad itself.
- Accepts a key code over a valid/ready handshake, then presses, holds and releases that key under counter control.
- Used for board self-test and as the responder in scanner benches; drops in where the physical keypad connects.

Parameters:
HOLD_CYCLES, 2000000, clk cycles the key stays pressed (must exceed the scanner debounce window)
RELEASE_CYCLES, 2000000, clk cycles of guaranteed release before the next request is accepted
CNT_W, 24, counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, RELEASE_CYCLES)
BOUNCE_CYCLES, 262144, bounce window length (used only with BOUNCE_EN)
BOUNCE_PERIOD, 4096, contact toggle interval inside the bounce window (used only with BOUNCE_EN)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous, active-low reset
key_code  in  4  hex code of key to press
key_valid  in  1  request strobe
key_ready  out  1  high in IDLE; a request is accepted when key_valid && key_ready at posedge clk
rowwrite  in  4  active-low row strobe from scanner (1110 = row0 … 0111 = row3)
colread  out  4  active-low column return to scanner (1111 = nothing pressed)
busy  out  1  high in PRESS or RELEASE
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, colread=4'b1111, key_ready=1, busy=0, done=0, counter=0, latched code=0.
  - Reset mid-operation forces colread=1111 immediately, without waiting for a clock edge.
- Key map (row, column):
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
  - Column c drives colread with bit c low (col0=1110, col1=1101, col2=1011, col3=0111).
- colread is registered, with one clk of latency from rowwrite.
  - Next value is the target column pattern when the key is asserted pressed AND rowwrite equals the latched row's one-hot-low pattern.
  - Otherwise the next value is 1111.
  - Rowwrite values that are not exactly one-hot-low (1111, 0000, 1100, …) give 1111.
- FSM:
  - IDLE:
    - key_ready=1.
    - On accept: latch key_code, decode row/col, load counter with HOLD_CYCLES-1, go to PRESS.
  - PRESS:
    - Key asserted pressed.
    - Counter decrements each clk. At 0: load RELEASE_CYCLES-1, go to RELEASE.
    - The key is pressed for exactly HOLD_CYCLES clks.
  - RELEASE:
    - Key not pressed.
    - Counter decrements each clk. At 0: go to IDLE and pulse done on that transition edge.
    - key_ready rises on the same edge.
- key_valid while key_ready=0 is ignored, with no queueing. key_code changes after accept have no effect.
- Back-to-back requests:
  - A request held valid across done is accepted on the first IDLE cycle.
  - Minimum request-to-request spacing is HOLD_CYCLES+RELEASE_CYCLES+1 clks.
- Counter width: all arithmetic is unsigned CNT_W bits. Parameters exceeding the counter range are a configuration error; a simulation-time check flags them.

Optional Feature:
- Macro: KEYPAD_BOUNCE_EN.
- When defined, the first BOUNCE_CYCLES clks of PRESS and of RELEASE emulate contact bounce:
  - The pressed condition toggles every BOUNCE_PERIOD clks.
  - Bounce starts pressed in PRESS and released in RELEASE.
  - The final level of each phase is its nominal level.
  - Total PRESS and RELEASE durations are unchanged.
- When undefined: clean press/release, no bounce logic or counter synthesized.

Test Plan:
- Reset: assert rst_n=0 mid-PRESS with rowwrite=1101, key 5 → colread=1111 asynchronously, key_ready=1, busy=0, done=0.
- Decode (HOLD=8, RELEASE=4): accept key 5, rowwrite=1101 → colread=1101 one clk later; rowwrite=1110 → 1111; rowwrite=1100 → 1111.
- Timing (HOLD=8, RELEASE=4): accept at edge 0 → busy high edges 1–12, pattern driven for 8 clks, done high exactly one clk at edge 12, key_ready=1 same cycle.
- Handshake: key_valid=1 with code 3 during PRESS of key 7 → ignored; held valid → accepted on the first IDLE edge after done; row0/colread=1011 observed next.
- Corner codes: key 0 with rowwrite=0111 → colread=1101; key D → 0111; key E → 1110; key A with rowwrite=1110 → 0111.
- Integration with the scanner (default parameters): press keys 1,2,3,F in sequence → scanner keyout 1,2,3,F with one ready/ack per key; repeat with KEYPAD_BOUNCE_EN defined → same four codes, no duplicates.
